// File: rtl/aes_word_packer.sv
// aes_word_packer: packs WORD_WIDTH-bit words big-endian into WORDS_PER_BLOCK-word blocks
// for the AES core, streaming back-to-back blocks without a bubble.
module aes_word_packer #(
   parameter int WORD_WIDTH      = 32,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clear,
   input  logic                                  in_valid,
   input  logic [WORD_WIDTH-1:0]                 in_word,
   output logic                                  in_ready,
   output logic                                  blk_valid,
   output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] blk_data,
   input  logic                                  blk_ready,
   output logic [$clog2(WORDS_PER_BLOCK):0]      word_cnt
);
   localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
   typedef enum logic {FILL, FULL} state_e;
   state_e                               state_q, state_d;
   logic [CW-1:0]                        cnt_q, cnt_d, slot;
   logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] data_q, data_d;
   logic                                 in_hs, last;
   assign in_ready  = ~clear && (state_q == FILL || blk_ready);
   assign in_hs     = in_valid && in_ready;
   assign last      = cnt_q == CW'(WORDS_PER_BLOCK - 1);
   assign blk_valid = state_q == FULL;
   assign blk_data  = data_q;
   assign word_cnt  = cnt_q;
   // A word accepted while draining a full block restarts the next block at the top slice.
   assign slot = (state_q == FULL) ? '0 : cnt_q;
   always_comb begin
      state_d = clear ? FILL
              : (state_q == FILL) ? ((in_hs && last) ? FULL : FILL)
              : (blk_ready ? FILL : FULL);
      cnt_d   = clear ? '0
              : (state_q == FILL) ? cnt_q + CW'(in_hs)
              : (blk_ready ? CW'(in_hs) : cnt_q);
      data_d  = data_q;
      for (int i = 0; i < WORDS_PER_BLOCK; i++)
         if (in_hs && slot == CW'(i)) data_d[(WORDS_PER_BLOCK-1-i)*WORD_WIDTH +: WORD_WIDTH] = in_word;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_aes_word_packer.sv
// tb_aes_word_packer: directed and randomized checks of the word packer with default parameters.
module tb_aes_word_packer;
   logic         clk = 1'b0;
   logic         rst, clear, in_valid, in_ready, blk_valid, blk_ready;
   logic [31:0]  in_word;
   logic [127:0] blk_data;
   logic [2:0]   word_cnt;
   int           passes = 0, total = 0;

   aes_word_packer dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_word(in_word),
      .in_ready(in_ready), .blk_valid(blk_valid), .blk_data(blk_data),
      .blk_ready(blk_ready), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic send(input logic [31:0] w);
      in_valid = 1'b1;
      in_word  = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] sb[$];
      logic        full, ir;
      int          acc, cyc, n;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_word = 32'hDEADBEEF; blk_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", blk_valid, 0);
      chk("rst_cnt", word_cnt, 0);
      chk("rst_data", blk_data, 0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      // single block under backpressure
      send(32'h00112233); send(32'h44556677); send(32'h8899AABB);
      chk("sb_cnt3", word_cnt, 3);
      chk("sb_valid3", blk_valid, 0);
      send(32'hCCDDEEFF);
      chk("sb_valid", blk_valid, 1);
      chk("sb_data", blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      chk("sb_cnt4", word_cnt, 4);
      chk("sb_in_ready", in_ready, 0);
      in_valid = 1'b1; in_word = 32'hFFFFFFFF;
      repeat (10) @(posedge clk);
      #1;
      chk("hold_data", blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      chk("hold_cnt", word_cnt, 4);
      chk("hold_valid", blk_valid, 1);
      in_valid = 1'b0; blk_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("drain_valid", blk_valid, 0);
      chk("drain_cnt", word_cnt, 0);
      // streaming: three blocks back to back
      in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_word = 32'h1000_0000 + 32'(i);
         @(posedge clk);
         #1;
         n = i + 1;
         chk("st_valid", blk_valid, (n % 4) == 0);
         chk("st_cnt", word_cnt, (n % 4) == 0 ? 4 : n % 4);
         if (n % 4 == 0)
            chk("st_data", blk_data, {32'(32'h1000_0000 + n - 4), 32'(32'h1000_0000 + n - 3),
                                      32'(32'h1000_0000 + n - 2), 32'(32'h1000_0000 + n - 1)});
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("st_end_cnt", word_cnt, 0);
      chk("st_end_valid", blk_valid, 0);
      // clear mid-block
      blk_ready = 1'b0;
      send(32'hAAAA0001); send(32'hAAAA0002);
      chk("cl_cnt2", word_cnt, 2);
      clear = 1'b1; in_valid = 1'b1; in_word = 32'hBADBAD00;
      #1;
      chk("cl_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0;
      chk("cl_cnt0", word_cnt, 0);
      send(32'hC0000001); send(32'hC0000002); send(32'hC0000003); send(32'hC0000004);
      chk("cl_valid", blk_valid, 1);
      chk("cl_data", blk_data, 128'hC0000001_C0000002_C0000003_C0000004);
      // clear coincident with output handshake
      clear = 1'b1; blk_ready = 1'b1; in_valid = 1'b1; in_word = 32'h77777777;
      #1;
      chk("co_in_ready", in_ready, 0);
      chk("co_delivered", blk_valid && blk_ready, 1);
      @(posedge clk);
      #1;
      clear = 1'b0; blk_ready = 1'b0; in_valid = 1'b0;
      chk("co_valid", blk_valid, 0);
      chk("co_cnt", word_cnt, 0);
      send(32'hD0000001); send(32'hD0000002); send(32'hD0000003); send(32'hD0000004);
      chk("co_data", blk_data, 128'hD0000001_D0000002_D0000003_D0000004);
      chk("co_cnt4", word_cnt, 4);
      blk_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("co_drain_cnt", word_cnt, 0);
      // random backpressure and gaps against a word-queue scoreboard
      acc = 0; cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
         in_valid  = ($urandom % 4) != 0;
         in_word   = $urandom;
         blk_ready = ($urandom % 3) != 0;
         #1;
         full = sb.size() == 4;
         ir   = !full || blk_ready;
         chk("rnd_in_ready", in_ready, ir);
         chk("rnd_valid", blk_valid, full);
         chk("rnd_cnt", word_cnt, sb.size());
         if (full) chk("rnd_data", blk_data, {sb[0], sb[1], sb[2], sb[3]});
         if (full && blk_ready) sb.delete();
         if (in_valid && ir) begin
            sb.push_back(in_word);
            acc++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      chk("rnd_words", acc, 1000);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/aes_word_packer.md
# aes_word_packer

Collects 32-bit words from the APB write-data path (the output of the APB/UART source-select multiplexer) into 128-bit blocks for the AES core. It sits directly downstream of that multiplexer and upstream of the AES core input register. It uses valid/ready handshakes on both sides. Back-to-back blocks stream at one word per cycle with no bubble.

## Interface
Parameters:
- WORD_WIDTH, 32, width of each input word.
- WORDS_PER_BLOCK, 4, words per output block; legal values are 2 to 16.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort; discards the partial block.
- in_valid  input  1  producer has a word on in_word.
- in_word  input  WORD_WIDTH  word from the source-select multiplexer.
- in_ready  output  1  packer accepts in_word this cycle.
- blk_valid  output  1  a complete block is held on blk_data.
- blk_data  output  WORD_WIDTH*WORDS_PER_BLOCK  assembled block.
- blk_ready  input  1  AES core accepts the block this cycle.
- word_cnt  output  $clog2(WORDS_PER_BLOCK)+1  words currently held, 0 to WORDS_PER_BLOCK.

## Operation
- An input handshake occurs when in_valid && in_ready. An output handshake occurs when blk_valid && blk_ready.
- Word order is big-endian:
  - The first word accepted goes to blk_data[top WORD_WIDTH bits]; for the default parameters that is [127:96].
  - Word k goes to slice (WORDS_PER_BLOCK-1-k).
- States:
  - FILL: collecting words; word_cnt runs from 0 to WORDS_PER_BLOCK-1.
  - FULL: block held; blk_valid=1 and word_cnt=WORDS_PER_BLOCK.
- FILL transitions:
  - Each input handshake writes the slice for the current count and increments word_cnt.
  - The handshake that fills the last slice moves the packer to FULL on the next edge.
- FULL transitions:
  - blk_data and blk_valid hold stable until the output handshake.
  - Output handshake with no input handshake: go to FILL, word_cnt=0.
  - Output handshake and input handshake in the same cycle: go to FILL with word_cnt=1 and the new word in slice 0 (top). Stale lower slices are don't-care and are not exposed, because blk_valid=0.
- in_ready = ~clear && (state==FILL || blk_ready). This is a combinational path from blk_ready; the consumer must not derive blk_ready from in_ready.
- clear behaviour:
  - Forces in_ready low, so no word is accepted in a clear cycle.
  - Next state is FILL with word_cnt=0.
  - If clear coincides with an output handshake, the block counts as delivered, since the consumer saw it. Otherwise a held block is dropped.
- rst has priority over clear, and clear has priority over handshakes.
- blk_data is not cleared on clear; it is only meaningful while blk_valid=1.

## Timing
- Reset values (cycle after rst is sampled high): state FILL, blk_valid=0, blk_data=0, word_cnt=0. in_ready is 1 once rst deasserts, provided clear=0.
- Reset mid-block or mid-FULL aborts the block with no output handshake.
- Latency: blk_valid rises on the edge after the last word's handshake, so one cycle after the final in_valid sample.
- Throughput with in_valid and blk_ready held high is one block every WORDS_PER_BLOCK cycles, with no idle cycle.
- If blk_ready stays low in FULL, in_ready=0 and the producer stalls. Nothing is lost or overwritten.
- in_valid low in FILL holds state and data; there is no timeout.
- word_cnt changes only on a clock edge; it never exceeds WORDS_PER_BLOCK.

## Test plan
- **Reset:** assert rst for 2 cycles with in_valid=1 -> blk_valid=0, word_cnt=0, blk_data=0. After release, in_ready=1.
- **Single block:** feed 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with blk_ready=0.
  - Required: blk_valid=1 one cycle after the 4th word.
  - Required: blk_data=0x00112233_44556677_8899AABB_CCDDEEFF, word_cnt=4, in_ready=0.
  - Holding blk_ready=0 for 10 cycles must leave data stable.
- **Streaming:** 3 blocks, in_valid=1 and blk_ready=1 continuously.
  - Required: blk_valid pulses on cycles 4, 8 and 12 after the first word, with correct contents.
  - Required: the simultaneous FULL-drain/accept cycle leaves word_cnt=1.
- **Clear mid-block:** clear after 2 words -> word_cnt=0 on the next edge. The next 4 words form a clean block containing no residue of the first two words.
- **Clear coincident with output handshake:** clear=1, blk_ready=1 in FULL.
  - Required: block counted as delivered; in_ready=0 that cycle.
  - Required: next state FILL with word_cnt=0, and an in_valid word in that cycle is not consumed.
- **Backpressure and gaps:** random in_valid/blk_ready over 1000 words with a scoreboard -> no lost, duplicated or reordered words. word_cnt always equals the scoreboard count.
